// File: rtl/dac_frame_serializer.sv
// ---------------------------------------------------------------------------
// dac_frame_serializer
//
// Accepts 16-bit tone samples on a valid/ready stream and shifts each one out
// to the board DAC as a 24-bit frame: 8-bit control prefix (CTRL_WORD), then
// the sample, MSB first. DAC_SCLK idles high. The DAC samples DAC_DATA on the
// falling edge of DAC_SCLK. DAC_DATA only changes on rising edges.
//
// Handshake: a sample transfers on a rising clk_in edge where
// s_valid && s_ready. s_ready is high only in IDLE, so there is no buffering.
// s_valid may drop before acceptance, and nothing is sent in that case.
//
// Optional build macro: DAC_SER_TWOS_COMP_EN
//   defined   - s_data is signed two's complement. It is converted to offset
//               binary by inverting bit 15 when the sample transfers.
//   undefined - s_data is sent unchanged (straight binary).
//
// Ports:
//   clk_in       system clock
//   reset        synchronous, active-high reset
//   s_data       sample to send
//   s_valid      sample available
//   s_ready      block can accept a sample (IDLE)
//   DAC_DATA     serial data, MSB first
//   DAC_SCLK     serial clock, idles high
//   DAC_SYNC_n   frame strobe, active low
//   busy         high while a frame or the inter-frame gap is in progress
//   frame_done   one-cycle pulse on the cycle DAC_SYNC_n returns high
//   dbg_state_o  current FSM state (IDLE=0, SHIFT=1, GAP=2)
// ---------------------------------------------------------------------------
module dac_frame_serializer #(
    parameter int unsigned CLK_DIV    = 2,     // clk_in cycles per SCLK half-period, 1..255
    parameter logic [7:0]  CTRL_WORD  = 8'h00, // prefix sent ahead of each sample
    parameter int unsigned GAP_CYCLES = 4      // SYNC_n high cycles between frames, 1..255
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        DAC_DATA,
    output logic        DAC_SCLK,
    output logic        DAC_SYNC_n,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    logic [1:0]  state_q,   state_d;
    logic [23:0] shift_q,   shift_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        sclk_q,    sclk_d;
    logic        sync_n_q,  sync_n_d;
    logic        data_q,    data_d;
    logic        ready_q,   ready_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

    logic [15:0] sample_conv;
    logic [23:0] frame_word;

`ifdef DAC_SER_TWOS_COMP_EN
    // Flipping the sign bit maps two's complement onto offset binary.
    assign sample_conv = {~s_data[15], s_data[14:0]};
`else
    assign sample_conv = s_data;
`endif

    assign frame_word = {CTRL_WORD, sample_conv};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        data_d    = data_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (s_valid && ready_q) begin
                    // First bit goes out with SCLK high on the very next cycle.
                    state_d   = ST_SHIFT;
                    shift_d   = frame_word;
                    data_d    = frame_word[23];
                    sync_n_d  = 1'b0;
                    sclk_d    = 1'b1;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;                 // DAC samples here
                    end else if (bit_cnt_q == BIT_LAST) begin
                        // End of the last low half: close the frame.
                        sclk_d    = 1'b1;
                        sync_n_d  = 1'b1;
                        data_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        // Rising edge: advance to the next bit.
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                        data_d    = shift_q[22];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                data_d   = 1'b0;
                ready_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            data_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready     = ready_q;
    assign DAC_DATA    = data_q;
    assign DAC_SCLK    = sclk_q;
    assign DAC_SYNC_n  = sync_n_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign dbg_state_o = state_q;

endmodule
